// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_if
//  Description : Byte-stream input handshake and instruction-memory write
//                port bundle for the program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
    parameter int WORD = 32
);
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            mem_wr_en;
    logic [WORD-1:0] mem_wr_addr;
    logic [WORD-1:0] mem_wr_data;

    // Stream source / memory sink side
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data
    );

    // Loader side
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Receives a length-prefixed, checksummed byte stream, packs
//                it big-endian into words, writes them to instruction memory
//                and holds the CPU in reset until a good image is loaded.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int WORD  = 32,
    parameter int DEPTH = 256
) (
    input  wire logic        clk,
    input  wire logic        rst,          // asynchronous, active-low
    input  wire logic        start,
    prog_loader_if.slave     bus,
    output logic             cpu_rst,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      words_loaded
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_HI = 4'd1,
        ST_LEN_LO = 4'd2,
        ST_DATA   = 4'd3,
        ST_WRITE  = 4'd4,
        ST_CHK    = 4'd5,
        ST_DONE   = 4'd6,
        ST_ERR    = 4'd7
    } state_t;

    // One extra bit so that a 16-bit count can be compared against DEPTH
    localparam logic [16:0] c_depth = 17'(DEPTH);

    state_t           state_q,    state_d;
    logic [7:0]       len_hi_q,   len_hi_d;
    logic [15:0]      count_q,    count_d;
    logic [15:0]      words_q,    words_d;
    logic [WORD-9:0]  asm_q,      asm_d;       // bytes already received of the current word
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]       csum_q,     csum_d;
    logic [WORD-1:0]  addr_q,     addr_d;
    logic [WORD-1:0]  data_q,     data_d;

    logic             w_in_ready;
    logic             w_xfer;
    logic [15:0]      w_count;
    logic [15:0]      w_words_inc;
    logic [WORD-1:0]  w_word;

    assign w_in_ready  = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                         (state_q == ST_DATA)   || (state_q == ST_CHK);
    assign w_xfer      = bus.in_valid && w_in_ready;
    assign w_count     = {len_hi_q, bus.in_data};
    assign w_words_inc = words_q + 16'd1;
    assign w_word      = {asm_q, bus.in_data};

    // Next-state and datapath update; everything holds unless a transfer or WRITE occurs
    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        count_d    = count_q;
        words_d    = words_q;
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LEN_HI;
                    words_d    = 16'd0;
                    csum_d     = 8'd0;
                    byte_cnt_d = 2'd0;
                end
            end
            ST_LEN_HI: begin
                if (w_xfer) begin
                    len_hi_d = bus.in_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_xfer) begin
                    count_d = w_count;
                    if ({1'b0, w_count} > c_depth) begin
                        state_d = ST_ERR;
                    end else if (w_count == 16'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    asm_d      = w_word[WORD-9:0];
                    csum_d     = csum_q ^ bus.in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Capture address and word now so they are stable throughout WRITE
                        state_d = ST_WRITE;
                        addr_d  = WORD'({words_q, 2'b00});
                        data_d  = w_word;
                    end
                end
            end
            ST_WRITE: begin
                words_d = w_words_inc;
                state_d = (w_words_inc < count_q) ? ST_DATA : ST_CHK;
            end
            ST_CHK: begin
                if (w_xfer) begin
                    state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_hi_q   <= 8'd0;
            count_q    <= 16'd0;
            words_q    <= 16'd0;
            asm_q      <= '0;
            byte_cnt_q <= 2'd0;
            csum_q     <= 8'd0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            count_q    <= count_d;
            words_q    <= words_d;
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // Status outputs decode straight from the state so reset takes effect immediately
    assign bus.in_ready    = w_in_ready;
    assign bus.mem_wr_en   = (state_q == ST_WRITE);
    assign bus.mem_wr_addr = addr_q;
    assign bus.mem_wr_data = data_q;
    assign busy            = w_in_ready || (state_q == ST_WRITE);
    assign done            = (state_q == ST_DONE);
    assign error           = (state_q == ST_ERR);
    assign cpu_rst         = (state_q != ST_DONE);
    assign words_loaded    = words_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Directed self-checking bench for prog_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks;
    int failures;

    // Write monitor storage
    logic [31:0] wa [0:299];
    logic [31:0] wd [0:299];
    int          nw;
    logic [7:0]  csum;

    prog_loader_if #(.WORD(32)) ifc ();

    prog_loader #(.WORD(32), .DEPTH(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (ifc.slave),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe seen mid-cycle
    always @(negedge clk) begin
        if (ifc.mem_wr_en === 1'b1) begin
            if (nw < 300) begin
                wa[nw] = ifc.mem_wr_addr;
                wd[nw] = ifc.mem_wr_data;
            end
            nw = nw + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Offer one byte and wait (bounded) for it to be accepted
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        while (ifc.in_ready !== 1'b1 && guard < 50) begin
            tick(1);
            guard++;
        end
        if (guard >= 50) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL handshake_timeout observed=in_ready_low expected=in_ready_high");
        end
        tick(1);
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'hEE;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[k*8 +: 8]);
            csum = csum ^ w[k*8 +: 8];
        end
    endtask

    initial begin
        int nw0;
        checks       = 0;
        failures     = 0;
        nw           = 0;
        csum         = 8'h00;
        rst          = 1'b0;
        start        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;

        // Reset values while rst is held low
        #12;
        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        chk("rst_cpu_rst",  {31'd0, cpu_rst}, 32'd1);
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        chk("rst_done_err", {30'd0, done, error}, 32'd0);
        chk("rst_words",    {16'd0, words_loaded}, 32'd0);
        chk("rst_wr",       {31'd0, ifc.mem_wr_en}, 32'd0);
        chk("rst_addr",     ifc.mem_wr_addr, 32'd0);
        chk("rst_data",     ifc.mem_wr_data, 32'd0);

        @(posedge clk); #1;
        rst = 1'b1;
        ifc.in_valid = 1'b1;      // valid without start must not move the loader
        tick(3);
        chk("idle_hold", {30'd0, busy, ifc.in_ready}, 32'd0);
        ifc.in_valid = 1'b0;

        // Good two-word load
        nw = 0; csum = 8'h00;
        pulse_start();
        chk("start_busy", {29'd0, busy, cpu_rst, ifc.in_ready}, 32'h7);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        chk("lat_wr_en", {31'd0, ifc.mem_wr_en}, 32'd1);
        chk("lat_addr",  ifc.mem_wr_addr, 32'h0);
        chk("lat_data",  ifc.mem_wr_data, 32'h20080005);
        tick(1);
        chk("wr_one_cycle", {31'd0, ifc.mem_wr_en}, 32'd0);
        chk("wr_data_hold", ifc.mem_wr_data, 32'h20080005);
        send_byte(8'hAC); send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
        tick(1);
        send_byte(8'h84);
        chk("good_flags", {28'd0, done, error, cpu_rst, busy}, 32'h8);
        chk("good_words", {16'd0, words_loaded}, 32'd2);
        chk("good_nw",    nw, 2);
        chk("good_w1",    wa[1], 32'h4);
        chk("good_d1",    wd[1], 32'hAC010004);

        // Same stream, bad checksum
        nw = 0;
        pulse_start();
        chk("restart_done_clr", {30'd0, done, busy}, 32'h1);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hAC); send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
        tick(1);
        send_byte(8'h85);
        chk("bad_flags", {28'd0, done, error, cpu_rst, busy}, 32'h6);
        chk("bad_nw",    nw, 2);

        // Oversized count
        nw = 0;
        pulse_start();
        send_byte(8'h01); send_byte(8'h01);
        chk("big_flags", {29'd0, error, ifc.in_ready, busy}, 32'h4);
        tick(2);
        chk("big_nw", nw, 0);

        // Empty image, good then bad checksum
        nw = 0;
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("empty_good", {29'd0, done, error, cpu_rst}, 32'h4);
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h5A);
        chk("empty_bad", {29'd0, done, error, cpu_rst}, 32'h3);
        chk("empty_nw", nw, 0);

        // One word with stalls and a stray start mid-load
        nw = 0;
        pulse_start();
        send_byte(8'h00); tick(1);
        send_byte(8'h01); tick(1);
        send_byte(8'h11); start = 1'b1; tick(1); start = 1'b0;
        send_byte(8'h22); tick(1);
        send_byte(8'h33); tick(1);
        send_byte(8'h44); tick(1);
        send_byte(8'h44);
        chk("stall_flags", {29'd0, done, error, cpu_rst}, 32'h4);
        chk("stall_nw",    nw, 1);
        chk("stall_addr",  wa[0], 32'h0);
        chk("stall_data",  wd[0], 32'h11223344);
        chk("stall_words", {16'd0, words_loaded}, 32'd1);

        // Full-depth image
        nw = 0; csum = 8'h00;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send_word({b, 8'hA5, ~b, 8'h3C});
            tick(1);
        end
        send_byte(csum);
        chk("full_done",  {30'd0, done, error}, 32'h2);
        chk("full_words", {16'd0, words_loaded}, 32'd256);
        chk("full_nw",    nw, 256);
        chk("full_last_a", wa[255], 32'h3FC);
        chk("full_last_d", wd[255], 32'hFFA5003C);
        chk("full_mid_d",  wd[7],   32'h07A5F83C);

        // Reset in the middle of a word
        nw = 0;
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_flags", {28'd0, busy, cpu_rst, ifc.in_ready, ifc.mem_wr_en}, 32'h4);
        chk("mid_rst_words", {16'd0, words_loaded}, 32'd0);
        chk("mid_rst_data",  ifc.mem_wr_data, 32'd0);
        ifc.in_valid = 1'b1; ifc.in_data = 8'hDD;
        tick(3);
        ifc.in_valid = 1'b0;
        rst = 1'b1;
        tick(2);
        chk("mid_rst_nw",   nw, 0);
        chk("mid_rst_idle", {31'd0, busy}, 32'd0);
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        tick(1);
        send_byte(8'h22);
        chk("clean_flags", {29'd0, done, error, cpu_rst}, 32'h4);
        chk("clean_nw",    nw, 1);
        chk("clean_data",  wd[0], 32'hDEADBEEF);
        chk("clean_addr",  wa[0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter WORD, default 32: memory word width in bits.
REQ-002 Parameter DEPTH, default 256: instruction memory size in words; legal word counts are 0..DEPTH.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 start  input  1: begin a load session; sampled only in IDLE, DONE or ERR.
REQ-006 in_valid  input  1: byte stream source has data.
REQ-007 in_data  input  8: stream byte.
REQ-008 in_ready  output  1: loader accepts a byte; a transfer occurs on a cycle with in_valid=1 and in_ready=1.
REQ-009 mem_wr_en  output  1: one-cycle instruction memory write strobe.
REQ-010 mem_wr_addr  output  WORD: byte address of the write, always word-aligned.
REQ-011 mem_wr_data  output  WORD: word to be written.
REQ-012 cpu_rst  output  1: active-high hold-reset to the processor core.
REQ-013 busy  output  1: session in progress.
REQ-014 done  output  1: last session completed with a good checksum.
REQ-015 error  output  1: last session aborted.
REQ-016 words_loaded  output  16: number of words written in the current or last session.

Function
REQ-017 States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR.
REQ-018 Stream format: count[15:8], count[7:0], then 4*count data bytes (big-endian per word, first byte goes to bits 31:24), then one checksum byte.
REQ-019 in_ready = 1 only in LEN_HI, LEN_LO, DATA and CHK; in_ready = 0 in IDLE, WRITE, DONE and ERR.
REQ-020 IDLE/DONE/ERR with start=1 -> LEN_HI; on that edge cpu_rst=1, busy=1, done=0, error=0, words_loaded=0, and the checksum accumulator is cleared.
REQ-021 LEN_HI -> LEN_LO on a transfer; LEN_LO -> DATA on a transfer, latching count.
REQ-022 At the LEN_LO transfer: count > DEPTH -> ERR; count = 0 -> CHK.
REQ-023 DATA: each transfer shifts the byte into the word assembler and XORs it into the 8-bit checksum; the 4th byte of a word moves the state to WRITE.
REQ-024 WRITE lasts exactly one cycle with mem_wr_en=1, mem_wr_addr = 4*words_loaded (pre-increment value) and mem_wr_data = the assembled word.
REQ-025 On leaving WRITE, words_loaded increments; the next state is DATA if words_loaded+1 < count, otherwise CHK.
REQ-026 Write latency: mem_wr_en is asserted in the cycle immediately after the 4th byte is accepted.
REQ-027 mem_wr_en = 0 in every state other than WRITE; mem_wr_addr and mem_wr_data hold their last values outside WRITE.
REQ-028 CHK: on a transfer, a byte equal to the accumulated XOR -> DONE; any other byte -> ERR.
REQ-029 DONE: busy=0, done=1, cpu_rst=0, starting from the first cycle in DONE.
REQ-030 ERR: busy=0, error=1, cpu_rst stays 1.
REQ-031 start while busy=1 is ignored.
REQ-032 in_valid=0 stalls any state indefinitely without side effects.
REQ-033 in_data is ignored when no transfer occurs.
REQ-034 count = DEPTH is legal; the last write address is 4*(DEPTH-1), with no wrap-around.

Reset
REQ-035 While rst=0, asynchronously: state=IDLE, cpu_rst=1, in_ready=0, mem_wr_en=0, busy=0, done=0, error=0, words_loaded=0, mem_wr_addr=0, mem_wr_data=0, checksum=0.
REQ-036 A reset asserted mid-session aborts the session with no further write strobes.
REQ-037 After rst rises, the loader stays in IDLE until start.

Verification
REQ-038 Stream 00 02 | 20 08 00 05 | AC 01 00 04 | checksum (XOR of the 8 data bytes) -> writes 0x20080005 at address 0 and 0xAC010004 at address 4; done=1; cpu_rst=0; words_loaded=2.
REQ-039 Same stream with the checksum byte XORed with 0x01 -> error=1, done=0, cpu_rst=1, two writes still observed.
REQ-040 Header 01 01 (257 > DEPTH) -> ERR immediately after the LEN_LO transfer; zero writes; in_ready=0.
REQ-041 Header 00 00, checksum 00 -> DONE with zero writes; a checksum of 5A instead -> ERR.
REQ-042 Valid 1-word load with in_valid toggled every other cycle and start pulsed mid-load -> identical write and result to the unstalled case; start has no effect.
REQ-043 rst pulled low after 3 data bytes -> all outputs at reset values within the same cycle; no mem_wr_en; a subsequent start runs a clean session.
